// File: rtl/issue_unit_pkg.sv
// rtl/issue_unit_pkg.sv - shared core definitions: unit-select encodings, issue FSM states
package issue_unit_pkg;

  localparam int REG_IDX_W = 5;
  localparam int SEL_W     = 3;
  localparam int UOP_W     = 4;

  // One-hot execution unit selects, shared with the decoder
  localparam logic [SEL_W-1:0] UNIT_ALU = 3'b001;
  localparam logic [SEL_W-1:0] UNIT_LSU = 3'b010;
  localparam logic [SEL_W-1:0] UNIT_VEC = 3'b100;

  typedef enum logic [1:0] {
    ISS_EMPTY    = 2'd0,
    ISS_HAZARD   = 2'd1,
    ISS_DISPATCH = 2'd2,
    ISS_ILLEGAL  = 2'd3
  } iss_state_e;

  // A select is legal only if it names exactly one known unit
  function automatic logic sel_is_legal(input logic [SEL_W-1:0] sel);
    return (sel == UNIT_ALU) || (sel == UNIT_LSU) || (sel == UNIT_VEC);
  endfunction

endpackage

// File: rtl/issue_unit_scoreboard.sv
// rtl/issue_unit_scoreboard.sv - GPR busy vector with one set, one clear and three read ports
module issue_unit_scoreboard
  import issue_unit_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 set_en_in,
  input  logic [REG_IDX_W-1:0] set_idx_in,
  input  logic                 clr_en_in,
  input  logic [REG_IDX_W-1:0] clr_idx_in,
  input  logic [REG_IDX_W-1:0] rd_idx_a_in,
  input  logic [REG_IDX_W-1:0] rd_idx_b_in,
  input  logic [REG_IDX_W-1:0] rd_idx_c_in,
  output logic                 busy_a_out,
  output logic                 busy_b_out,
  output logic                 busy_c_out
);

  logic [NUM_REGS-1:0] busy_q;

  // Index 0 is hardwired idle, so the lookup only scans 1..NUM_REGS-1
  function automatic logic lookup(input logic [REG_IDX_W-1:0] idx,
                                  input logic [NUM_REGS-1:0]  vec);
    logic hit;
    hit = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == REG_IDX_W'(i)) hit = vec[i];
    end
    return hit;
  endfunction

  // Busy bits: a set beats a same-cycle clear of the same register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (set_en_in && (set_idx_in == REG_IDX_W'(i))) busy_q[i] <= 1'b1;
        else if (clr_en_in && (clr_idx_in == REG_IDX_W'(i))) busy_q[i] <= 1'b0;
      end
    end
  end

  assign busy_a_out = lookup(rd_idx_a_in, busy_q);
  assign busy_b_out = lookup(rd_idx_b_in, busy_q);
  assign busy_c_out = lookup(rd_idx_c_in, busy_q);

endmodule

// File: rtl/issue_unit.sv
// rtl/issue_unit.sv - single-entry issue stage with scoreboard hazard check and one-hot dispatch
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   dec_valid_in,
  output logic                   dec_ready_out,
  input  logic [SEL_W-1:0]       exec_unit_sel_in,
  input  logic [UOP_W-1:0]       exec_unit_uop_in,
  input  logic [REG_IDX_W-1:0]   rs1_in,
  input  logic [REG_IDX_W-1:0]   rs2_in,
  input  logic [REG_IDX_W-1:0]   rd_in,
  input  logic                   rs1_used_in,
  input  logic                   rs2_used_in,
  input  logic                   rd_we_in,
  output logic [SEL_W-1:0]       iss_valid_out,
  input  logic [SEL_W-1:0]       iss_ready_in,
  output logic [UOP_W-1:0]       iss_uop_out,
  output logic [REG_IDX_W-1:0]   iss_rs1_out,
  output logic [REG_IDX_W-1:0]   iss_rs2_out,
  output logic [REG_IDX_W-1:0]   iss_rd_out,
  input  logic                   wb_valid_in,
  input  logic [REG_IDX_W-1:0]   wb_rd_in,
  input  logic                   flush_in,
  output logic                   illegal_out,
  output logic [STALL_CNT_W-1:0] stall_cnt_out
);

  iss_state_e             state_q, state_d;
  logic [SEL_W-1:0]       sel_q;
  logic [UOP_W-1:0]       uop_q;
  logic [REG_IDX_W-1:0]   rs1_q, rs2_q, rd_q;
  logic                   rs1_used_q, rs2_used_q, rd_we_q;
  logic [STALL_CNT_W-1:0] stall_q;

  logic                   handshake, accept, set_en, in_hazard, hazard;
  logic [REG_IDX_W-1:0]   chk_rs1, chk_rs2, chk_rd;
  logic                   chk_rs1_used, chk_rs2_used, chk_rd_we;
  logic                   busy_rs1, busy_rs2, busy_rd;

  // Dispatch handshake and decoder back-pressure; flush suppresses both
  always_comb begin
    iss_valid_out = (state_q == ISS_DISPATCH && !flush_in) ? sel_q : '0;
    handshake     = |(iss_valid_out & iss_ready_in);
    dec_ready_out = !flush_in && ((state_q == ISS_EMPTY) || handshake);
    accept        = dec_valid_in && dec_ready_out;
    set_en        = handshake && rd_we_q && (rd_q != '0);
  end

  // Hazard check: held fields while stalled, incoming fields otherwise.
  // A destination being set by this cycle's dispatch is forwarded so a
  // dependent follower is caught; writebacks are never forwarded.
  always_comb begin
    in_hazard    = (state_q == ISS_HAZARD);
    chk_rs1      = in_hazard ? rs1_q      : rs1_in;
    chk_rs2      = in_hazard ? rs2_q      : rs2_in;
    chk_rd       = in_hazard ? rd_q       : rd_in;
    chk_rs1_used = in_hazard ? rs1_used_q : rs1_used_in;
    chk_rs2_used = in_hazard ? rs2_used_q : rs2_used_in;
    chk_rd_we    = in_hazard ? rd_we_q    : rd_we_in;
    hazard = (chk_rs1_used && (busy_rs1 || (set_en && rd_q == chk_rs1))) ||
             (chk_rs2_used && (busy_rs2 || (set_en && rd_q == chk_rs2))) ||
             (chk_rd_we    && (busy_rd  || (set_en && rd_q == chk_rd)));
  end

  issue_unit_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .set_en_in   (set_en),
    .set_idx_in  (rd_q),
    .clr_en_in   (wb_valid_in),
    .clr_idx_in  (wb_rd_in),
    .rd_idx_a_in (chk_rs1),
    .rd_idx_b_in (chk_rs2),
    .rd_idx_c_in (chk_rd),
    .busy_a_out  (busy_rs1),
    .busy_b_out  (busy_rs2),
    .busy_c_out  (busy_rd)
  );

  // Next-state selection; flush overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ISS_EMPTY: begin
        if (accept) begin
          if (!sel_is_legal(exec_unit_sel_in)) state_d = ISS_ILLEGAL;
          else if (hazard)                     state_d = ISS_HAZARD;
          else                                 state_d = ISS_DISPATCH;
        end
      end
      ISS_HAZARD: begin
        if (!hazard) state_d = ISS_DISPATCH;
      end
      ISS_DISPATCH: begin
        if (handshake) begin
          if (!accept)                              state_d = ISS_EMPTY;
          else if (!sel_is_legal(exec_unit_sel_in)) state_d = ISS_ILLEGAL;
          else if (hazard)                          state_d = ISS_HAZARD;
          else                                      state_d = ISS_DISPATCH;
        end
      end
      ISS_ILLEGAL: state_d = ISS_ILLEGAL;
      default:     state_d = ISS_EMPTY;
    endcase
    if (flush_in) state_d = ISS_EMPTY;
  end

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= ISS_EMPTY;
    else           state_q <= state_d;
  end

  // Issue register: captures every field on accept and holds until the next one
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sel_q      <= '0;
      uop_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_used_q <= 1'b0;
      rs2_used_q <= 1'b0;
      rd_we_q    <= 1'b0;
    end else if (accept) begin
      sel_q      <= exec_unit_sel_in;
      uop_q      <= exec_unit_uop_in;
      rs1_q      <= rs1_in;
      rs2_q      <= rs2_in;
      rd_q       <= rd_in;
      rs1_used_q <= rs1_used_in;
      rs2_used_q <= rs2_used_in;
      rd_we_q    <= rd_we_in;
    end
  end

  // Saturating count of cycles spent stalled on a hazard
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stall_q <= '0;
    end else if (!flush_in && state_q == ISS_HAZARD && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign iss_uop_out   = uop_q;
  assign iss_rs1_out   = rs1_q;
  assign iss_rs2_out   = rs2_q;
  assign iss_rd_out    = rd_q;
  assign illegal_out   = (state_q == ISS_ILLEGAL);
  assign stall_cnt_out = stall_q;

endmodule

// File: tb/tb_issue_unit.sv
// tb/tb_issue_unit.sv - randomized self-checking bench for issue_unit against a behavioural model
module tb_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid, dec_ready;
  logic [2:0]  sel;
  logic [3:0]  uop;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_used, rs2_used, rd_we;
  logic [2:0]  iss_valid, iss_ready;
  logic [3:0]  iss_uop;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush, illegal;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  issue_unit #(.NUM_REGS(32), .STALL_CNT_W(16)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .dec_valid_in(dec_valid), .dec_ready_out(dec_ready),
    .exec_unit_sel_in(sel), .exec_unit_uop_in(uop),
    .rs1_in(rs1), .rs2_in(rs2), .rd_in(rd),
    .rs1_used_in(rs1_used), .rs2_used_in(rs2_used), .rd_we_in(rd_we),
    .iss_valid_out(iss_valid), .iss_ready_in(iss_ready),
    .iss_uop_out(iss_uop), .iss_rs1_out(iss_rs1), .iss_rs2_out(iss_rs2), .iss_rd_out(iss_rd),
    .wb_valid_in(wb_valid), .wb_rd_in(wb_rd),
    .flush_in(flush), .illegal_out(illegal), .stall_cnt_out(stall_cnt)
  );

  // Behavioural model: is an instruction held, is it illegal, is it waiting on a hazard
  logic [31:0] m_busy;
  bit          m_have, m_illegal, m_wait;
  logic [2:0]  m_sel;
  logic [3:0]  m_uop;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  bit          m_u1, m_u2, m_we;
  int          m_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_have = 0; m_illegal = 0; m_wait = 0;
    m_sel = '0; m_uop = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    m_u1 = 0; m_u2 = 0; m_we = 0; m_stall = 0;
  endtask

  function automatic bit haz(input logic [4:0] r1, input bit u1, input logic [4:0] r2, input bit u2,
                             input logic [4:0] rdi, input bit we, input logic [31:0] vec);
    return (u1 && vec[r1]) || (u2 && vec[r2]) || (we && vec[rdi]);
  endfunction

  // One clock: compare at the falling edge, then advance the model at the rising edge
  task automatic cycle();
    bit          disp, hs, acc;
    logic [2:0]  exp_valid;
    bit          exp_ready;
    logic [31:0] pend;
    @(negedge clk);
    disp      = m_have && !m_illegal && !m_wait && !flush;
    exp_valid = disp ? m_sel : 3'b000;
    hs        = (exp_valid & iss_ready) != 3'b000;
    exp_ready = !flush && (!m_have || hs);
    check("dec_ready", dec_ready, exp_ready);
    check("iss_valid", iss_valid, exp_valid);
    check("illegal", illegal, m_have && m_illegal);
    check("iss_uop", iss_uop, m_uop);
    check("iss_rs1", iss_rs1, m_rs1);
    check("iss_rs2", iss_rs2, m_rs2);
    check("iss_rd", iss_rd, m_rd);
    check("stall_cnt", stall_cnt, m_stall);
    check("busy", dut.u_scoreboard.busy_q, m_busy);
    acc  = rst_n && dec_valid && exp_ready;
    pend = (hs && m_we && m_rd != 0) ? (32'd1 << m_rd) : 32'd0;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!flush && m_have && m_wait) begin
        if (m_stall < 65535) m_stall++;
        if (!haz(m_rs1, m_u1, m_rs2, m_u2, m_rd, m_we, m_busy)) m_wait = 0;
      end
      if (hs) m_have = 0;
      if (flush) begin
        m_have = 0; m_illegal = 0; m_wait = 0;
      end
      if (acc) begin
        m_have = 1; m_sel = sel; m_uop = uop; m_rs1 = rs1; m_rs2 = rs2; m_rd = rd;
        m_u1 = rs1_used; m_u2 = rs2_used; m_we = rd_we;
        m_illegal = !(sel == 3'b001 || sel == 3'b010 || sel == 3'b100);
        m_wait = !m_illegal && haz(rs1, rs1_used, rs2, rs2_used, rd, rd_we, m_busy | pend);
      end
      if (wb_valid && wb_rd != 0) m_busy[wb_rd] = 1'b0;
      m_busy = m_busy | pend;
    end
    #1;
  endtask

  task automatic set_instr(input bit v, input logic [2:0] s, input logic [3:0] u,
                           input logic [4:0] a, input bit ua, input logic [4:0] b, input bit ub,
                           input logic [4:0] d, input bit w);
    dec_valid = v; sel = s; uop = u; rs1 = a; rs1_used = ua; rs2 = b; rs2_used = ub; rd = d; rd_we = w;
  endtask

  initial begin
    rst_n = 1'b0; flush = 0; wb_valid = 0; wb_rd = '0; iss_ready = '0;
    set_instr(0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check("reset_dec_ready", dec_ready, 1);
    check("reset_iss_valid", iss_valid, 0);
    cycle(); cycle();
    rst_n = 1'b1;

    // ALU add rd=5: dispatch the next cycle, rd=5 busy after handshake
    set_instr(1, 3'b001, 4'h1, 1, 1, 2, 1, 5, 1); iss_ready = 3'b001;
    cycle();
    dec_valid = 0;
    #2 check("alu_valid_n1", iss_valid, 3'b001);
    cycle();
    #2 check("busy5_set", dut.u_scoreboard.busy_q[5], 1);

    // Reader of r5 stalls until the writeback three cycles later
    set_instr(1, 3'b001, 4'h2, 5, 1, 0, 0, 0, 0); iss_ready = 3'b000;
    cycle();
    dec_valid = 0;
    cycle(); cycle();
    wb_valid = 1; wb_rd = 5;
    cycle();
    wb_valid = 0;
    cycle();
    #2 check("stall_cnt_4", stall_cnt, 4);
    check("raw_dispatch", iss_valid, 3'b001);
    iss_ready = 3'b001;
    cycle();

    // LSU back-pressured for three cycles
    set_instr(1, 3'b010, 4'h3, 0, 0, 0, 0, 9, 0); iss_ready = 3'b000;
    cycle();
    set_instr(1, 3'b001, 4'h4, 1, 1, 2, 1, 10, 1);
    for (int i = 0; i < 3; i++) begin
      #2 check("lsu_valid_held", iss_valid, 3'b010);
      check("lsu_dec_ready", dec_ready, 0);
      check("lsu_uop_stable", iss_uop, 4'h3);
      cycle();
    end
    iss_ready = 3'b010;
    #2 check("lsu_hs_ready", dec_ready, 1);
    cycle();
    dec_valid = 0; iss_ready = 3'b001;
    cycle(); cycle();
    wb_valid = 1; wb_rd = 10;
    cycle();
    wb_valid = 0;

    // Set and clear of r7 in one cycle leaves it busy; rd=0 never busy
    set_instr(1, 3'b001, 4'h5, 0, 0, 0, 0, 7, 1); iss_ready = 3'b000;
    cycle();
    dec_valid = 0; iss_ready = 3'b001; wb_valid = 1; wb_rd = 7;
    cycle();
    wb_valid = 0;
    #2 check("busy7_set_wins", dut.u_scoreboard.busy_q[7], 1);
    set_instr(1, 3'b001, 4'h6, 0, 0, 0, 0, 0, 1);
    cycle();
    dec_valid = 0;
    cycle();
    #2 check("busy0_never", dut.u_scoreboard.busy_q[0], 0);

    // Illegal select holds until flush
    set_instr(1, 3'b000, 4'h7, 0, 0, 0, 0, 1, 1);
    cycle();
    set_instr(1, 3'b001, 4'h8, 0, 0, 0, 0, 2, 0); iss_ready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      #2 check("illegal_out", illegal, 1);
      check("illegal_no_valid", iss_valid, 0);
      check("illegal_no_ready", dec_ready, 0);
      cycle();
    end
    flush = 1;
    cycle();
    flush = 0; dec_valid = 0;
    #2 check("flush_ready", dec_ready, 1);
    check("flush_illegal", illegal, 0);
    cycle();

    // Reset while dispatching
    set_instr(1, 3'b001, 4'h9, 0, 0, 0, 0, 3, 1); iss_ready = 3'b000;
    cycle();
    dec_valid = 0;
    #2 check("pre_reset_valid", iss_valid, 3'b001);
    check("pre_reset_busy", dut.u_scoreboard.busy_q, 32'h0000_0080);
    rst_n = 0;
    model_reset();
    #1 check("reset_valid_now", iss_valid, 0);
    check("reset_busy_now", dut.u_scoreboard.busy_q, 0);
    check("reset_ready_now", dec_ready, 1);
    cycle(); cycle();
    rst_n = 1;
    cycle();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      dec_valid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 9))
        0:       sel = 3'($urandom);
        1, 2, 3: sel = 3'b001;
        4, 5, 6: sel = 3'b010;
        default: sel = 3'b100;
      endcase
      uop = 4'($urandom); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      rs1_used = $urandom_range(0, 1); rs2_used = $urandom_range(0, 1); rd_we = $urandom_range(0, 1);
      iss_ready = 3'($urandom);
      wb_valid = ($urandom_range(0, 9) < 3); wb_rd = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0;
        model_reset();
        cycle();
        rst_n = 1;
      end else begin
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
